control_pipe_unit: RTL and testbench
====================================

Name: control_pipe_unit

Overview:
Pipelined successor to the single-cycle main decoder. Decodes the ID-stage opcode/funct into a control bundle, registers it into the ID/EX stage, and adds BNE/J/HALT decoding. Also provides load-use hazard bubbling, branch flush, external stall, a halt-drain state machine and an issued-instruction counter. Sits between IF/ID and ID/EX pipeline registers in the datapath top.

Parameters:
NBITS, 6, opcode width
FUNCT_NBITS, 6, funct field width
REG_NBITS, 5, register index width
DRAIN_CYCLES, 3, cycles spent in HALT_DRAIN before HALTED (>=1)
COUNT_NBITS, 32, issued-instruction counter width

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_Opcode  in  NBITS  ID-stage opcode
i_Funct  in  FUNCT_NBITS  ID-stage funct (R-type NOP check only)
i_Rs  in  REG_NBITS  ID-stage rs
i_Rt  in  REG_NBITS  ID-stage rt
i_Flush  in  1  branch/jump taken in later stage; kill ID instruction
i_Stall_Ext  in  1  external stall (memory busy); freeze
o_RegDst, o_Branch, o_BranchNE, o_Jump, o_MemRead, o_MemToReg, o_MemWrite, o_ALUSrc, o_RegWrite  out  1 each  registered EX-stage controls
o_ALUOp  out  2  registered EX-stage ALU op class
o_EX_Rt  out  REG_NBITS  registered rt of EX instruction
o_PCWrite  out  1  combinational PC enable
o_IFIDWrite  out  1  combinational IF/ID enable
o_Halted  out  1  registered, high in HALTED
o_IssueCount  out  COUNT_NBITS  registered count of non-NOP bundles issued

Behaviour:
- Reset (async, i_reset_n=0): all registered outputs 0, state RUN, drain counter 0, internal EX_MemRead 0.
- Decode (comb): R 000000 -> RegDst,RegWrite=1, ALUOp=10. LW 100011 -> MemRead,MemToReg,ALUSrc,RegWrite=1, ALUOp=00. SW 101011 -> MemWrite,ALUSrc=1, ALUOp=00. BEQ 000100 -> Branch=1, ALUOp=01. BNE 000101 -> BranchNE=1, ALUOp=01. J 000010 -> Jump=1. HALT 111111 -> NOP bundle. Others -> NOP bundle (all zero). R-type with funct=0 and rt=0 (sll $0) is a NOP bundle.
- uses_rt = R-type, SW, BEQ, BNE.
- hazard = EX_MemRead & (EX_Rt != 0) & (EX_Rt == i_Rs | (uses_rt & EX_Rt == i_Rt)).
- Per-cycle priority in RUN: i_Flush > i_Stall_Ext > hazard > HALT opcode > normal.
  - Flush: EX <= NOP, o_EX_Rt <= 0; PCWrite=1, IFIDWrite=1.
  - Ext stall: EX regs and counter hold; PCWrite=0, IFIDWrite=0.
  - Hazard: EX <= NOP (one bubble); PCWrite=0, IFIDWrite=0; clears next cycle since EX_MemRead=0.
  - HALT: EX <= NOP; state -> HALT_DRAIN, drain counter <= 0; PCWrite=0, IFIDWrite=0.
  - Normal: EX <= decoded bundle, o_EX_Rt <= i_Rt; PCWrite=1, IFIDWrite=1.
- o_IssueCount increments by 1 when a non-NOP bundle enters EX; wraps modulo 2^COUNT_NBITS.
- State HALT_DRAIN: EX <= NOP every cycle; PCWrite=IFIDWrite=0; i_Flush and i_Stall_Ext ignored; counter increments; at count DRAIN_CYCLES-1 -> HALTED.
- State HALTED: o_Halted=1, EX held at NOP, PCWrite=IFIDWrite=0; leaves only via reset.
- Reset mid-drain or mid-stall returns to RUN immediately, counter cleared.

Optional Feature:
CTRL_IMM_OPS_EN: when defined, ADDI 001000, ANDI 001100, ORI 001101 decode to ALUSrc=1, RegWrite=1, RegDst=0, ALUOp=11 (EX ALU control resolves via opcode), and count as issued; they do not use rt for hazard detection. When undefined, these opcodes decode as NOP bundle and are not counted.

Test Plan:
- Reset, then R-type (op 0, funct 100000, rs=1, rt=2) -> next cycle RegDst=1, RegWrite=1, ALUOp=10, o_IssueCount=1, PCWrite=1.
- LW rt=5 then ADD rs=5 -> cycle after LW: PCWrite=0, IFIDWrite=0, EX NOP for one cycle; ADD issues next cycle; count=2 total.
- LW rt=0 then ADD rs=0 -> no bubble, PCWrite stays 1.
- BEQ issued with i_Flush=1 same cycle -> EX bundle all zero, count unchanged; i_Stall_Ext=1 for 2 cycles -> outputs and count hold exactly.
- HALT opcode, DRAIN_CYCLES=3 -> PCWrite=0 from that cycle, o_Halted=1 three cycles after HALT registered; i_Flush during drain has no effect; async reset mid-drain -> o_Halted=0, RUN.
- COUNT_NBITS=4, issue 17 R-types -> o_IssueCount=1; with CTRL_IMM_OPS_EN, ADDI -> ALUSrc=1, RegWrite=1, ALUOp=11; without, ADDI -> all zero, count unchanged.

Source files
------------

// File: rtl/control_pipe_unit.sv
// control_pipe_unit
//   Decodes the ID-stage opcode/funct into a control bundle and registers it
//   into the ID/EX stage. Also handles load-use bubbling, branch flush,
//   external stall, a halt-drain state machine and an issued-instruction
//   counter.
//
// Ports:
//   i_clk, i_reset_n          clock (rising edge), async active-low reset
//   i_Opcode, i_Funct         ID-stage opcode / funct
//   i_Rs, i_Rt                ID-stage source register indices
//   i_Flush                   kill the ID instruction (taken branch/jump later)
//   i_Stall_Ext               freeze the pipe (memory busy)
//   o_RegDst .. o_ALUOp       registered EX-stage control bundle
//   o_EX_Rt                   registered rt of the EX instruction
//   o_PCWrite, o_IFIDWrite    combinational PC and IF/ID enables
//   o_Halted                  high once the halt drain has completed
//   o_IssueCount              count of non-NOP bundles issued into EX
//
// Optional feature macro: CTRL_IMM_OPS_EN
//   When defined, ADDI/ANDI/ORI decode to an immediate ALU bundle
//   (ALUSrc=1, RegWrite=1, ALUOp=11) and are counted as issued.
module control_pipe_unit #(
  parameter int unsigned NBITS        = 6,
  parameter int unsigned FUNCT_NBITS  = 6,
  parameter int unsigned REG_NBITS    = 5,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned COUNT_NBITS  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NBITS-1:0]       i_Opcode,
  input  logic [FUNCT_NBITS-1:0] i_Funct,
  input  logic [REG_NBITS-1:0]   i_Rs,
  input  logic [REG_NBITS-1:0]   i_Rt,
  input  logic                   i_Flush,
  input  logic                   i_Stall_Ext,
  output logic                   o_RegDst,
  output logic                   o_Branch,
  output logic                   o_BranchNE,
  output logic                   o_Jump,
  output logic                   o_MemRead,
  output logic                   o_MemToReg,
  output logic                   o_MemWrite,
  output logic                   o_ALUSrc,
  output logic                   o_RegWrite,
  output logic [1:0]             o_ALUOp,
  output logic [REG_NBITS-1:0]   o_EX_Rt,
  output logic                   o_PCWrite,
  output logic                   o_IFIDWrite,
  output logic                   o_Halted,
  output logic [COUNT_NBITS-1:0] o_IssueCount
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [NBITS-1:0] OP_R    = NBITS'(0);
  localparam logic [NBITS-1:0] OP_LW   = NBITS'(35);
  localparam logic [NBITS-1:0] OP_SW   = NBITS'(43);
  localparam logic [NBITS-1:0] OP_BEQ  = NBITS'(4);
  localparam logic [NBITS-1:0] OP_BNE  = NBITS'(5);
  localparam logic [NBITS-1:0] OP_J    = NBITS'(2);
  localparam logic [NBITS-1:0] OP_HALT = NBITS'(63);
`ifdef CTRL_IMM_OPS_EN
  localparam logic [NBITS-1:0] OP_ADDI = NBITS'(8);
  localparam logic [NBITS-1:0] OP_ANDI = NBITS'(12);
  localparam logic [NBITS-1:0] OP_ORI  = NBITS'(13);
`endif

  typedef struct packed {
    logic       RegDst;
    logic       Branch;
    logic       BranchNE;
    logic       Jump;
    logic       MemRead;
    logic       MemToReg;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic [1:0] ALUOp;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT_DRAIN,
    ST_HALTED
  } state_t;

  state_t                 r_state;
  logic [DW-1:0]          r_drain_cnt;
  ctrl_t                  r_ex;
  logic [REG_NBITS-1:0]   r_ex_rt;
  logic                   r_halted;
  logic [COUNT_NBITS-1:0] r_issue_cnt;

  ctrl_t w_dec;
  logic  w_uses_rt;
  logic  w_is_halt;
  logic  w_is_nop;
  logic  w_hazard;
  logic  w_advance;

  always_comb begin
    w_dec     = '0;
    w_uses_rt = 1'b0;
    w_is_halt = 1'b0;
    unique case (i_Opcode)
      OP_R: begin
        w_uses_rt = 1'b1;
        // sll $0 form is the canonical NOP; leave the bundle empty
        if (!(i_Funct == '0 && i_Rt == '0)) begin
          w_dec.RegDst   = 1'b1;
          w_dec.RegWrite = 1'b1;
          w_dec.ALUOp    = 2'b10;
        end
      end
      OP_LW: begin
        w_dec.MemRead  = 1'b1;
        w_dec.MemToReg = 1'b1;
        w_dec.ALUSrc   = 1'b1;
        w_dec.RegWrite = 1'b1;
      end
      OP_SW: begin
        w_uses_rt      = 1'b1;
        w_dec.MemWrite = 1'b1;
        w_dec.ALUSrc   = 1'b1;
      end
      OP_BEQ: begin
        w_uses_rt    = 1'b1;
        w_dec.Branch = 1'b1;
        w_dec.ALUOp  = 2'b01;
      end
      OP_BNE: begin
        w_uses_rt      = 1'b1;
        w_dec.BranchNE = 1'b1;
        w_dec.ALUOp    = 2'b01;
      end
      OP_J: begin
        w_dec.Jump = 1'b1;
      end
      OP_HALT: begin
        w_is_halt = 1'b1;
      end
`ifdef CTRL_IMM_OPS_EN
      OP_ADDI, OP_ANDI, OP_ORI: begin
        w_dec.ALUSrc   = 1'b1;
        w_dec.RegWrite = 1'b1;
        w_dec.ALUOp    = 2'b11;
      end
`endif
      default: begin
        w_dec = '0;
      end
    endcase
  end

  assign w_is_nop = (w_dec == '0);

  assign w_hazard = r_ex.MemRead && (r_ex_rt != '0) &&
                    ((r_ex_rt == i_Rs) || (w_uses_rt && (r_ex_rt == i_Rt)));

  // Only a normal issue in RUN (or a flush, which discards IF/ID anyway) lets
  // the front end advance.
  always_comb begin
    w_advance = 1'b0;
    if (r_state == ST_RUN) begin
      if (i_Flush)
        w_advance = 1'b1;
      else if (i_Stall_Ext || w_hazard || w_is_halt)
        w_advance = 1'b0;
      else
        w_advance = 1'b1;
    end
  end

  assign o_PCWrite   = w_advance;
  assign o_IFIDWrite = w_advance;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_ex        <= '0;
      r_ex_rt     <= '0;
      r_halted    <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_Flush) begin
            r_ex    <= '0;
            r_ex_rt <= '0;
          end else if (i_Stall_Ext) begin
            r_ex    <= r_ex;
            r_ex_rt <= r_ex_rt;
          end else if (w_hazard) begin
            r_ex    <= '0;
            r_ex_rt <= '0;
          end else if (w_is_halt) begin
            r_ex        <= '0;
            r_ex_rt     <= '0;
            r_drain_cnt <= '0;
            r_state     <= ST_HALT_DRAIN;
          end else begin
            r_ex    <= w_dec;
            r_ex_rt <= i_Rt;
            if (!w_is_nop)
              r_issue_cnt <= r_issue_cnt + COUNT_NBITS'(1);
          end
        end
        ST_HALT_DRAIN: begin
          r_ex    <= '0;
          r_ex_rt <= '0;
          if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
          end
        end
        ST_HALTED: begin
          r_ex     <= '0;
          r_ex_rt  <= '0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
          r_ex    <= '0;
          r_ex_rt <= '0;
        end
      endcase
    end
  end

  assign o_RegDst     = r_ex.RegDst;
  assign o_Branch     = r_ex.Branch;
  assign o_BranchNE   = r_ex.BranchNE;
  assign o_Jump       = r_ex.Jump;
  assign o_MemRead    = r_ex.MemRead;
  assign o_MemToReg   = r_ex.MemToReg;
  assign o_MemWrite   = r_ex.MemWrite;
  assign o_ALUSrc     = r_ex.ALUSrc;
  assign o_RegWrite   = r_ex.RegWrite;
  assign o_ALUOp      = r_ex.ALUOp;
  assign o_EX_Rt      = r_ex_rt;
  assign o_Halted     = r_halted;
  assign o_IssueCount = r_issue_cnt;

endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed bench for control_pipe_unit (DRAIN_CYCLES=3, COUNT_NBITS=4).
// Expected bundle order: {RegDst,Branch,BranchNE,Jump,MemRead,MemToReg,
// MemWrite,ALUSrc,RegWrite,ALUOp[1:0]}.
module tb_control_pipe_unit;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [5:0] i_Opcode;
  logic [5:0] i_Funct;
  logic [4:0] i_Rs;
  logic [4:0] i_Rt;
  logic       i_Flush;
  logic       i_Stall_Ext;
  logic       o_RegDst, o_Branch, o_BranchNE, o_Jump, o_MemRead;
  logic       o_MemToReg, o_MemWrite, o_ALUSrc, o_RegWrite;
  logic [1:0] o_ALUOp;
  logic [4:0] o_EX_Rt;
  logic       o_PCWrite, o_IFIDWrite, o_Halted;
  logic [3:0] o_IssueCount;

  control_pipe_unit #(
    .NBITS(6),
    .FUNCT_NBITS(6),
    .REG_NBITS(5),
    .DRAIN_CYCLES(3),
    .COUNT_NBITS(4)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_Opcode(i_Opcode),
    .i_Funct(i_Funct),
    .i_Rs(i_Rs),
    .i_Rt(i_Rt),
    .i_Flush(i_Flush),
    .i_Stall_Ext(i_Stall_Ext),
    .o_RegDst(o_RegDst),
    .o_Branch(o_Branch),
    .o_BranchNE(o_BranchNE),
    .o_Jump(o_Jump),
    .o_MemRead(o_MemRead),
    .o_MemToReg(o_MemToReg),
    .o_MemWrite(o_MemWrite),
    .o_ALUSrc(o_ALUSrc),
    .o_RegWrite(o_RegWrite),
    .o_ALUOp(o_ALUOp),
    .o_EX_Rt(o_EX_Rt),
    .o_PCWrite(o_PCWrite),
    .o_IFIDWrite(o_IFIDWrite),
    .o_Halted(o_Halted),
    .o_IssueCount(o_IssueCount)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111, OP_ADDI = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;

  localparam logic [10:0] B_NOP = 11'b00000000000;
  localparam logic [10:0] B_R   = 11'b10000000110;
  localparam logic [10:0] B_LW  = 11'b00001101100;
  localparam logic [10:0] B_SW  = 11'b00000011000;
  localparam logic [10:0] B_BEQ = 11'b01000000001;
  localparam logic [10:0] B_BNE = 11'b00100000001;
  localparam logic [10:0] B_J   = 11'b00010000000;
`ifdef CTRL_IMM_OPS_EN
  localparam logic [10:0] B_ADDI = 11'b00000001111;
  localparam int IMM = 1;
`else
  localparam logic [10:0] B_ADDI = 11'b00000000000;
  localparam int IMM = 0;
`endif

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        fl;
    logic        st;
    logic        pcw;
    logic [10:0] bun;
    logic        chk_rt;
    logic [4:0]  ert;
    logic [3:0]  cnt;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vt[20];

  function automatic logic [10:0] bundle();
    return {o_RegDst, o_Branch, o_BranchNE, o_Jump, o_MemRead, o_MemToReg,
            o_MemWrite, o_ALUSrc, o_RegWrite, o_ALUOp};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl, input logic st);
    i_Opcode = op; i_Funct = fn; i_Rs = rs; i_Rt = rt; i_Flush = fl; i_Stall_Ext = st;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                              input logic [4:0] rt, input logic fl, input logic st,
                              input logic pcw, input logic [10:0] bun, input logic chk_rt,
                              input logic [4:0] ert, input int cnt);
    vec_t v;
    v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.fl = fl; v.st = st;
    v.pcw = pcw; v.bun = bun; v.chk_rt = chk_rt; v.ert = ert; v.cnt = 4'(cnt);
    return v;
  endfunction

  initial begin
    int c;
    //            op       fn     rs  rt  fl st pcw bundle  crt ert cnt
    vt[0]  = mk(OP_R,    F_ADD, 1, 2, 0, 0, 1, B_R,    1, 2, 1);
    vt[1]  = mk(OP_LW,   0,     1, 5, 0, 0, 1, B_LW,   1, 5, 2);
    vt[2]  = mk(OP_R,    F_ADD, 5, 3, 0, 0, 0, B_NOP,  0, 0, 2);      // load-use via rs
    vt[3]  = mk(OP_R,    F_ADD, 5, 3, 0, 0, 1, B_R,    1, 3, 3);
    vt[4]  = mk(OP_LW,   0,     2, 0, 0, 0, 1, B_LW,   1, 0, 4);
    vt[5]  = mk(OP_R,    F_ADD, 0, 0, 0, 0, 1, B_R,    1, 0, 5);      // rt=0 load: no bubble
    vt[6]  = mk(OP_LW,   0,     1, 7, 0, 0, 1, B_LW,   1, 7, 6);
    vt[7]  = mk(OP_SW,   0,     2, 7, 0, 0, 0, B_NOP,  0, 0, 6);      // load-use via rt
    vt[8]  = mk(OP_SW,   0,     2, 7, 0, 0, 1, B_SW,   1, 7, 7);
    vt[9]  = mk(OP_BNE,  0,     1, 2, 0, 0, 1, B_BNE,  1, 2, 8);
    vt[10] = mk(OP_BEQ,  0,     1, 2, 1, 0, 1, B_NOP,  1, 0, 8);      // flush kills BEQ
    vt[11] = mk(OP_J,    0,     0, 3, 0, 0, 1, B_J,    1, 3, 9);
    vt[12] = mk(OP_R,    F_ADD, 1, 2, 0, 1, 0, B_J,    1, 3, 9);      // ext stall holds
    vt[13] = mk(OP_R,    F_ADD, 1, 2, 0, 1, 0, B_J,    1, 3, 9);
    vt[14] = mk(OP_R,    F_ADD, 1, 2, 1, 1, 1, B_NOP,  1, 0, 9);      // flush beats stall
    vt[15] = mk(OP_R,    0,     3, 0, 0, 0, 1, B_NOP,  1, 0, 9);      // sll $0 NOP
    vt[16] = mk(OP_ADDI, 0,     1, 4, 0, 0, 1, B_ADDI, 1, 4, 9 + IMM);
    vt[17] = mk(OP_LW,   0,     0, 6, 0, 0, 1, B_LW,   1, 6, 10 + IMM);
    vt[18] = mk(OP_R,    F_ADD, 1, 6, 0, 0, 0, B_NOP,  0, 0, 10 + IMM);
    vt[19] = mk(OP_R,    F_ADD, 1, 6, 0, 0, 1, B_R,    1, 6, 11 + IMM);

    // Reset state
    i_reset_n = 1'b0;
    drive(OP_R, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_bundle", 32'(bundle()), 32'(B_NOP));
    chk("rst_ex_rt", 32'(o_EX_Rt), 0);
    chk("rst_count", 32'(o_IssueCount), 0);
    chk("rst_halted", 32'(o_Halted), 0);
    i_reset_n = 1'b1;

    // Table-driven vectors: comb enables mid-cycle, registered outputs after edge
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].op, vt[i].fn, vt[i].rs, vt[i].rt, vt[i].fl, vt[i].st);
      #3;
      chk($sformatf("v%0d_pcwrite", i), 32'(o_PCWrite), 32'(vt[i].pcw));
      chk($sformatf("v%0d_ifidwrite", i), 32'(o_IFIDWrite), 32'(vt[i].pcw));
      tick();
      chk($sformatf("v%0d_bundle", i), 32'(bundle()), 32'(vt[i].bun));
      chk($sformatf("v%0d_count", i), 32'(o_IssueCount), 32'(vt[i].cnt));
      if (vt[i].chk_rt)
        chk($sformatf("v%0d_ex_rt", i), 32'(o_EX_Rt), 32'(vt[i].ert));
    end

    // Counter wrap: 17 more issues on a 4-bit counter nets +1
    c = 11 + IMM;
    drive(OP_R, F_ADD, 1, 2, 0, 0);
    repeat (17) tick();
    chk("wrap_count", 32'(o_IssueCount), 32'((c + 1) % 16));
    c = (c + 1) % 16;

    // HALT drain
    drive(OP_HALT, 0, 0, 0, 0, 0);
    #3;
    chk("halt_pcwrite", 32'(o_PCWrite), 0);
    chk("halt_ifidwrite", 32'(o_IFIDWrite), 0);
    tick();
    chk("halt_bundle", 32'(bundle()), 32'(B_NOP));
    chk("halt_halted0", 32'(o_Halted), 0);
    drive(OP_R, F_ADD, 1, 2, 1, 0);  // flush during drain must be ignored
    #3;
    chk("drain_pcwrite", 32'(o_PCWrite), 0);
    tick();
    chk("drain1_halted", 32'(o_Halted), 0);
    chk("drain1_bundle", 32'(bundle()), 32'(B_NOP));
    tick();
    chk("drain2_halted", 32'(o_Halted), 0);
    tick();
    chk("drain3_halted", 32'(o_Halted), 1);
    chk("drain_count", 32'(o_IssueCount), 32'(c));
    drive(OP_R, F_ADD, 1, 2, 0, 0);
    #3;
    chk("halted_pcwrite", 32'(o_PCWrite), 0);
    tick();
    chk("halted_bundle", 32'(bundle()), 32'(B_NOP));
    chk("halted_hold", 32'(o_Halted), 1);
    chk("halted_count", 32'(o_IssueCount), 32'(c));

    // Async reset in the middle of a drain
    i_reset_n = 1'b0;
    #1;
    i_reset_n = 1'b1;
    chk("rst2_halted", 32'(o_Halted), 0);
    drive(OP_HALT, 0, 0, 0, 0, 0);
    tick();
    drive(OP_R, F_ADD, 1, 2, 0, 0);
    tick();
    i_reset_n = 1'b0;
    #1;
    chk("middrain_rst_halted", 32'(o_Halted), 0);
    chk("middrain_rst_count", 32'(o_IssueCount), 0);
    chk("middrain_rst_pcwrite", 32'(o_PCWrite), 1);
    i_reset_n = 1'b1;
    tick();
    chk("after_rst_bundle", 32'(bundle()), 32'(B_R));
    chk("after_rst_count", 32'(o_IssueCount), 1);
    tick(); tick(); tick();
    chk("after_rst_nohalt", 32'(o_Halted), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
